// File: rtl/lsu_byte_master.sv
// Load/store initiator: splits a CPU load/store into byte accesses on a byte-wide
// synchronous RAM, assembles load data little-endian and extends it.
module lsu_byte_master #(
    parameter int ADDR_W      = 10,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state, nxt;
    logic            wr_q;
    logic [2:0]      type_q;
    logic [31:0]     wdata_q;
    logic [1:0]      cnt, cnt_nxt, last_q;
    logic            cap_vld;
    logic [1:0]      cap_idx;
    logic [3:0][7:0] rbuf;

    logic            accept, req_err, bad_type, misalign, out_range;
    logic [1:0]      req_last;
    logic [3:0][7:0] rbytes;
    logic [31:0]     load_res;

    assign req_ready = !rst && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign cnt_nxt   = cnt + 2'd1;

    // Request decode: index of the last byte and the three reject conditions
    always_comb begin
        bad_type  = (req_type == 3'b011) || (req_type == 3'b110) || (req_type == 3'b111);
        req_last  = req_type[1] ? 2'd3 : (req_type[0] ? 2'd1 : 2'd0);
        misalign  = ALIGN_CHECK && (((req_last == 2'd1) && req_addr[0]) ||
                                    ((req_last == 2'd3) && (req_addr[1:0] != 2'b00)));
        out_range = (req_addr >> ADDR_W) != 32'd0;
        req_err   = bad_type || misalign || out_range;
    end

    // The final load byte is still on mem_rdata when the result is formed
    always_comb begin
        for (int j = 0; j < 4; j++)
            rbytes[j] = (cap_vld && (cap_idx == 2'(j))) ? mem_rdata : rbuf[j];
        case (type_q)
            3'b000:  load_res = {{24{rbytes[0][7]}}, rbytes[0]};
            3'b001:  load_res = {{16{rbytes[1][7]}}, rbytes[1], rbytes[0]};
            3'b100:  load_res = {24'd0, rbytes[0]};
            3'b101:  load_res = {16'd0, rbytes[1], rbytes[0]};
            default: load_res = rbytes;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = req_err ? RESP : ACCESS;
            ACCESS:  if (cnt == last_q) nxt = wr_q ? RESP : WAIT;
            WAIT:    nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= 1'b0;
            type_q     <= 3'd0;
            wdata_q    <= 32'd0;
            cnt        <= 2'd0;
            last_q     <= 2'd0;
            cap_vld    <= 1'b0;
            cap_idx    <= 2'd0;
            rbuf       <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            // Read data returns one cycle after a read strobe
            cap_vld    <= mem_en && !mem_we;
            cap_idx    <= cnt;
            if (cap_vld) rbuf[cap_idx] <= mem_rdata;
            resp_valid <= (nxt == RESP);
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            if (accept) begin
                wr_q    <= req_write;
                type_q  <= req_type;
                wdata_q <= req_wdata;
                last_q  <= req_last;
                cnt     <= 2'd0;
                if (!req_err) begin
                    mem_en    <= 1'b1;
                    mem_we    <= req_write;
                    mem_addr  <= req_addr[ADDR_W-1:0];
                    mem_wdata <= req_wdata[7:0];
                end
            end else if ((state == ACCESS) && (cnt != last_q)) begin
                cnt       <= cnt_nxt;
                mem_en    <= 1'b1;
                mem_we    <= wr_q;
                mem_addr  <= mem_addr + ADDR_W'(1);
                mem_wdata <= wdata_q[{cnt_nxt, 3'b000} +: 8];
            end
            if (nxt == RESP) begin
                resp_err   <= (state == IDLE);
                resp_rdata <= (state == WAIT) ? load_res : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Directed bench for lsu_byte_master against a byte-wide synchronous RAM model.
module tb_lsu_byte_master;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst, req_valid, req_ready, req_write;
    logic [2:0]    req_type;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          ram_init;
    logic [7:0]    ram [0:(1<<AW)-1];

    int checks = 0;
    int failures = 0;

    lsu_byte_master #(.ADDR_W(AW), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < (1<<AW); i++) ram[i] <= 8'h00;
            ram[10'h021] <= 8'h80;
            ram[10'h040] <= 8'h34;
            ram[10'h041] <= 8'h92;
            mem_rdata    <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request and return latency (cycles from accept edge), strobe count and response
    task automatic do_req(input logic wr, input logic [2:0] ty, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output int men,
                          output logic err, output logic [31:0] rd);
        lat = -1; men = 0; err = 1'b0; rd = 32'd0;
        @(negedge clk);
        chk("ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_type = ty; req_addr = a; req_wdata = wd;
        @(posedge clk);
        for (int i = 0; i < 12 && lat < 0; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_en) men++;
            if (resp_valid) begin
                lat = i + 1; err = resp_err; rd = resp_rdata;
            end
        end
    endtask

    task automatic run(input string tag, input logic wr, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] wd, input int e_lat,
                       input int e_men, input logic e_err, input logic [31:0] e_rd);
        int lat, men;
        logic err;
        logic [31:0] rd;
        do_req(wr, ty, a, wd, lat, men, err, rd);
        chk({tag, ".lat"}, lat, e_lat);
        chk({tag, ".men"}, men, e_men);
        chk({tag, ".err"}, {31'd0, err}, {31'd0, e_err});
        chk({tag, ".rdata"}, rd, e_rd);
    endtask

    initial begin
        int seen_rv, seen_en;
        rst = 1'b1; ram_init = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_type = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;

        @(posedge clk); @(negedge clk);
        chk("rst.ready", {31'd0, req_ready}, 32'd0);
        chk("rst.flags", {28'd0, mem_en, mem_we, resp_valid, resp_err}, 32'd0);
        chk("rst.mem", {14'd0, mem_addr, mem_wdata}, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; ram_init = 1'b0;
        #1 chk("post_rst.ready", {31'd0, req_ready}, 32'd1);

        run("sw", 1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 5, 4, 1'b0, 32'd0);
        chk("sw.b0", {24'd0, ram[10'h010]}, 32'hD4);
        chk("sw.b1", {24'd0, ram[10'h011]}, 32'hC3);
        chk("sw.b2", {24'd0, ram[10'h012]}, 32'hB2);
        chk("sw.b3", {24'd0, ram[10'h013]}, 32'hA1);

        run("lb", 1'b0, 3'b000, 32'h21, 32'd0, 3, 1, 1'b0, 32'hFFFFFF80);
        @(negedge clk);
        chk("lb.pulse", {31'd0, resp_valid}, 32'd0);
        chk("lb.hold", resp_rdata, 32'hFFFFFF80);

        run("lbu", 1'b0, 3'b100, 32'h21, 32'd0, 3, 1, 1'b0, 32'h00000080);
        run("lh",  1'b0, 3'b001, 32'h40, 32'd0, 4, 2, 1'b0, 32'hFFFF9234);
        run("lhu", 1'b0, 3'b101, 32'h40, 32'd0, 4, 2, 1'b0, 32'h00009234);
        run("lw",  1'b0, 3'b010, 32'h10, 32'd0, 6, 4, 1'b0, 32'hA1B2C3D4);

        run("e_lw22",  1'b0, 3'b010, 32'h22,  32'd0,    1, 0, 1'b1, 32'd0);
        run("e_sh41",  1'b1, 3'b001, 32'h41,  32'hFFFF, 1, 0, 1'b1, 32'd0);
        chk("e_sh41.ram", {24'd0, ram[10'h041]}, 32'h92);
        run("e_ty011", 1'b0, 3'b011, 32'h0,   32'd0,    1, 0, 1'b1, 32'd0);
        run("e_range", 1'b0, 3'b000, 32'h400, 32'd0,    1, 0, 1'b1, 32'd0);
        // Issued in the cycle right after the previous response
        run("b2b_lb", 1'b0, 3'b000, 32'h21, 32'd0, 3, 1, 1'b0, 32'hFFFFFF80);

        // Reset lands on the edge that would start byte 1 of a word store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_type = 3'b010;
        req_addr = 32'h50; req_wdata = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_rv = 0; seen_en = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) seen_rv++;
            if (mem_en) seen_en++;
            @(negedge clk);
        end
        chk("abort.resp", seen_rv, 32'd0);
        chk("abort.men", seen_en, 32'd0);
        chk("abort.b0", {24'd0, ram[10'h050]}, 32'h44);
        chk("abort.b1", {24'd0, ram[10'h051]}, 32'h00);
        chk("abort.b2", {24'd0, ram[10'h052]}, 32'h00);
        chk("abort.b3", {24'd0, ram[10'h053]}, 32'h00);
        chk("abort.idle", {31'd0, req_ready}, 32'd1);

        run("after_abort", 1'b0, 3'b100, 32'h21, 32'd0, 3, 1, 1'b0, 32'h00000080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
